// File: rtl/ecc_pkg.sv
// ecc_pkg: shared types and constants for the ECC encoder sequencing slice.
// Holds the controller state enum, ctrl opcodes, work-mode codes and the
// info/codeword widths of each mode, plus a low-bit mask helper.
package ecc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] CTRL_ENC  = 2'b00;
  localparam logic [1:0] CTRL_FULL = 2'b10;

  localparam int unsigned MOD_1 = 0;  // 8-bit codeword
  localparam int unsigned MOD_2 = 1;  // 16-bit codeword
  localparam int unsigned MOD_3 = 2;  // 32-bit codeword

  localparam int unsigned INFO_W_1 = 4;
  localparam int unsigned INFO_W_2 = 11;
  localparam int unsigned INFO_W_3 = 26;

  localparam int unsigned CW_W_1 = 8;
  localparam int unsigned CW_W_2 = 16;
  localparam int unsigned CW_W_3 = 32;

  // Ones in bits [w-1:0], zeros above.
  function automatic logic [31:0] low_mask(input int unsigned w);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ecc_width_mask.sv
// ecc_width_mask: decodes a work mode into its info-field and codeword masks.
// Latency: combinational. Backpressure: none (pure decode).
// Ports: mode_i (work mode), info_mask_o, cw_mask_o, mode_ok_o (mode is legal).
module ecc_width_mask
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD          = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int MAX_CODEWORD_WIDTH = 32
) (
  input  logic [AMBA_WORD-1:0]          mode_i,
  output logic [MAX_INFO_WIDTH-1:0]     info_mask_o,
  output logic [MAX_CODEWORD_WIDTH-1:0] cw_mask_o,
  output logic                          mode_ok_o
);

  localparam logic [31:0] INFO_M1 = low_mask(INFO_W_1);
  localparam logic [31:0] INFO_M2 = low_mask(INFO_W_2);
  localparam logic [31:0] INFO_M3 = low_mask(INFO_W_3);
  localparam logic [31:0] CW_M1   = low_mask(CW_W_1);
  localparam logic [31:0] CW_M2   = low_mask(CW_W_2);
  localparam logic [31:0] CW_M3   = low_mask(CW_W_3);

  always_comb begin
    info_mask_o = '0;
    cw_mask_o   = '0;
    mode_ok_o   = 1'b0;
    if (mode_i == AMBA_WORD'(MOD_1)) begin
      info_mask_o = MAX_INFO_WIDTH'(INFO_M1);
      cw_mask_o   = MAX_CODEWORD_WIDTH'(CW_M1);
      mode_ok_o   = 1'b1;
    end else if (mode_i == AMBA_WORD'(MOD_2)) begin
      info_mask_o = MAX_INFO_WIDTH'(INFO_M2);
      cw_mask_o   = MAX_CODEWORD_WIDTH'(CW_M2);
      mode_ok_o   = 1'b1;
    end else if (mode_i == AMBA_WORD'(MOD_3)) begin
      info_mask_o = MAX_INFO_WIDTH'(INFO_M3);
      cw_mask_o   = MAX_CODEWORD_WIDTH'(CW_M3);
      mode_ok_o   = 1'b1;
    end
  end

endmodule

// File: rtl/ecc_enc_ctrl.sv
// ecc_enc_ctrl: sequences one ECC encoder-stage operation per start pulse.
// Latency: operation_done in cycle 2+ENC_LATENCY after start; rejected requests in cycle 1.
// Backpressure: none; start is ignored while busy, nothing is queued.
// Ports: start/ctrl/work_mod/data_in/noise from the register front end;
// enc_data_in/enc_work_mod drive the encoder stage, enc_data_out returns its codeword;
// data_out/operation_done/mode_err/busy report the result. All outputs registered.
// Optional feature macro: ECC_ENC_NOISE_EN enables ctrl=10 (codeword XOR noise).
module ecc_enc_ctrl
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD          = 32,
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int ENC_LATENCY        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    ctrl,
  input  logic [AMBA_WORD-1:0]          work_mod,
  input  logic [AMBA_WORD-1:0]          data_in,
  input  logic [AMBA_WORD-1:0]          noise,
  output logic [MAX_INFO_WIDTH-1:0]     enc_data_in,
  output logic [AMBA_WORD-1:0]          enc_work_mod,
  input  logic [MAX_CODEWORD_WIDTH-1:0] enc_data_out,
  output logic [AMBA_WORD-1:0]          data_out,
  output logic                          operation_done,
  output logic                          mode_err,
  output logic                          busy
);

  localparam int CNT_W = $clog2(ENC_LATENCY + 1);

  state_t                          state_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [MAX_INFO_WIDTH-1:0]       enc_data_in_q;
  logic [AMBA_WORD-1:0]            enc_work_mod_q;
  logic [AMBA_WORD-1:0]            data_out_q;
  logic                            done_q;
  logic                            err_q;
  logic                            busy_q;

`ifdef ECC_ENC_NOISE_EN
  logic [1:0]                      ctrl_q;
  logic [MAX_CODEWORD_WIDTH-1:0]   noise_q;
`endif

  // The mask decoder serves both ends of the operation: the live work_mod
  // while idle (to sanitise data_in), the latched mode afterwards (to mask
  // the captured codeword). enc_work_mod_q is that latched mode.
  logic [AMBA_WORD-1:0]            mode_sel;
  logic [MAX_INFO_WIDTH-1:0]       info_mask;
  logic [MAX_CODEWORD_WIDTH-1:0]   cw_mask;
  logic                            mode_ok;

  assign mode_sel = (state_q == ST_IDLE) ? work_mod : enc_work_mod_q;

  ecc_width_mask #(
    .AMBA_WORD          (AMBA_WORD),
    .MAX_INFO_WIDTH     (MAX_INFO_WIDTH),
    .MAX_CODEWORD_WIDTH (MAX_CODEWORD_WIDTH)
  ) u_mask (
    .mode_i      (mode_sel),
    .info_mask_o (info_mask),
    .cw_mask_o   (cw_mask),
    .mode_ok_o   (mode_ok)
  );

  logic ctrl_ok;
  logic req_ok;
  logic [MAX_INFO_WIDTH-1:0]     enc_data_in_d;
  logic [MAX_CODEWORD_WIDTH-1:0] cw_d;
  logic [AMBA_WORD-1:0]          data_out_d;

`ifdef ECC_ENC_NOISE_EN
  assign ctrl_ok = (ctrl == CTRL_ENC) || (ctrl == CTRL_FULL);
`else
  assign ctrl_ok = (ctrl == CTRL_ENC);
`endif
  assign req_ok        = ctrl_ok && mode_ok;
  assign enc_data_in_d = data_in[MAX_INFO_WIDTH-1:0] & info_mask;

  always_comb begin
    cw_d = enc_data_out;
`ifdef ECC_ENC_NOISE_EN
    if (ctrl_q == CTRL_FULL) cw_d = cw_d ^ noise_q;
`endif
    cw_d       = cw_d & cw_mask;
    data_out_d = AMBA_WORD'(cw_d);
  end

  // Bits above the info field are sanitised away; noise is dead without the feature.
`ifdef ECC_ENC_NOISE_EN
  logic unused_in;
  assign unused_in = ^data_in[AMBA_WORD-1:MAX_INFO_WIDTH];
`else
  logic unused_in;
  assign unused_in = ^{data_in[AMBA_WORD-1:MAX_INFO_WIDTH], noise};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      enc_data_in_q  <= '0;
      enc_work_mod_q <= '0;
      data_out_q     <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
`ifdef ECC_ENC_NOISE_EN
      ctrl_q         <= '0;
      noise_q        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            enc_work_mod_q <= work_mod;
            enc_data_in_q  <= enc_data_in_d;
            busy_q         <= 1'b1;
`ifdef ECC_ENC_NOISE_EN
            ctrl_q         <= ctrl;
            noise_q        <= noise[MAX_CODEWORD_WIDTH-1:0];
`endif
            if (req_ok) begin
              state_q <= ST_LOAD;
            end else begin
              // Rejection is reported in the very next cycle.
              state_q    <= ST_ERR;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              data_out_q <= '0;
            end
          end
        end
        ST_LOAD: begin
          cnt_q   <= CNT_W'(ENC_LATENCY - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            data_out_q <= data_out_d;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign enc_data_in    = enc_data_in_q;
  assign enc_work_mod   = enc_work_mod_q;
  assign data_out       = data_out_q;
  assign operation_done = done_q;
  assign mode_err       = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ecc_enc_ctrl.sv
// tb_ecc_enc_ctrl: directed bench for ecc_enc_ctrl at ENC_LATENCY 1 (dut) and 3 (dut3).
// The encoder stage is a stub: enc_data_out is a bench-held constant per step.
module tb_ecc_enc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  ctrl = 2'b00;
  logic [31:0] work_mod = '0;
  logic [31:0] data_in = '0;
  logic [31:0] noise = '0;
  logic [31:0] stub_cw = '0;

  logic [25:0] enc_data_in, enc_data_in3;
  logic [31:0] enc_work_mod, enc_work_mod3;
  logic [31:0] data_out, data_out3;
  logic        done, done3, err, err3, busy, busy3;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt;
  int done_cnt3;

  always #5 clk = ~clk;

  ecc_enc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ctrl           (ctrl),
    .work_mod       (work_mod),
    .data_in        (data_in),
    .noise          (noise),
    .enc_data_in    (enc_data_in),
    .enc_work_mod   (enc_work_mod),
    .enc_data_out   (stub_cw),
    .data_out       (data_out),
    .operation_done (done),
    .mode_err       (err),
    .busy           (busy)
  );

  ecc_enc_ctrl #(.ENC_LATENCY(3)) dut3 (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ctrl           (ctrl),
    .work_mod       (work_mod),
    .data_in        (data_in),
    .noise          (noise),
    .enc_data_in    (enc_data_in3),
    .enc_work_mod   (enc_work_mod3),
    .enc_data_out   (stub_cw),
    .data_out       (data_out3),
    .operation_done (done3),
    .mode_err       (err3),
    .busy           (busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present a request for one cycle; returns in cycle 1 of the operation.
  task automatic issue(input logic [1:0] c, input logic [31:0] wm,
                       input logic [31:0] d, input logic [31:0] nz);
    ctrl     = c;
    work_mod = wm;
    data_in  = d;
    noise    = nz;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    #2;
    chk("rst_enc_data_in", 32'(enc_data_in), 32'h0);
    chk("rst_enc_work_mod", enc_work_mod, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    idle(2);
    rst = 1'b1;
    idle(2);

    // ---- mode 2 (16-bit) encode, info masked to 11 bits ----
    stub_cw = 32'hDEAD_BEEF;
    issue(2'b00, 32'd1, 32'hFFFF_FFFF, 32'h0);
    chk("m2_c1_enc_data_in", 32'(enc_data_in), 32'h0000_07FF);
    chk("m2_c1_enc_work_mod", enc_work_mod, 32'd1);
    chk("m2_c1_busy", 32'(busy), 32'h1);
    chk("m2_c1_done", 32'(done), 32'h0);
    chk("lat3_c1_busy", 32'(busy3), 32'h1);
    step();
    chk("m2_c2_done", 32'(done), 32'h0);
    chk("m2_c2_busy", 32'(busy), 32'h1);
    step();
    chk("m2_c3_done", 32'(done), 32'h1);
    chk("m2_c3_err", 32'(err), 32'h0);
    chk("m2_c3_data_out", data_out, 32'h0000_BEEF);
    chk("m2_c3_busy", 32'(busy), 32'h1);
    chk("lat3_c3_done", 32'(done3), 32'h0);
    step();
    chk("m2_c4_done", 32'(done), 32'h0);
    chk("m2_c4_busy", 32'(busy), 32'h0);
    chk("m2_c4_data_out_hold", data_out, 32'h0000_BEEF);
    chk("lat3_c4_busy", 32'(busy3), 32'h1);
    chk("lat3_c4_done", 32'(done3), 32'h0);
    step();
    chk("lat3_c5_done", 32'(done3), 32'h1);
    chk("lat3_c5_busy", 32'(busy3), 32'h1);
    chk("lat3_c5_data_out", data_out3, 32'h0000_BEEF);
    step();
    chk("lat3_c6_done", 32'(done3), 32'h0);
    chk("lat3_c6_busy", 32'(busy3), 32'h0);
    idle(2);

    // ---- mode 1 (8-bit) encode ----
    stub_cw = 32'hA5A5_A5A5;
    issue(2'b00, 32'd0, 32'h1234_5678, 32'h0);
    chk("m1_c1_enc_data_in", 32'(enc_data_in), 32'h0000_0008);
    idle(2);
    chk("m1_c3_done", 32'(done), 32'h1);
    chk("m1_c3_data_out", data_out, 32'h0000_00A5);
    idle(5);

    // ---- mode 3 (32-bit) encode ----
    stub_cw = 32'h8765_4321;
    issue(2'b00, 32'd2, 32'hFFFF_FFFF, 32'h0);
    chk("m3_c1_enc_data_in", 32'(enc_data_in), 32'h03FF_FFFF);
    idle(2);
    chk("m3_c3_done", 32'(done), 32'h1);
    chk("m3_c3_data_out", data_out, 32'h8765_4321);
    idle(5);

    // ---- invalid work_mod ----
    issue(2'b00, 32'd3, 32'h0000_0001, 32'h0);
    chk("badmod_c1_done", 32'(done), 32'h1);
    chk("badmod_c1_err", 32'(err), 32'h1);
    chk("badmod_c1_data_out", data_out, 32'h0);
    chk("badmod_c1_busy", 32'(busy), 32'h1);
    chk("badmod_c1_enc_work_mod", enc_work_mod, 32'd3);
    chk("badmod_lat3_c1_err", 32'(err3), 32'h1);
    step();
    chk("badmod_c2_done", 32'(done), 32'h0);
    chk("badmod_c2_err", 32'(err), 32'h0);
    chk("badmod_c2_busy", 32'(busy), 32'h0);
    idle(2);

    // ---- invalid ctrl 01 ----
    issue(2'b01, 32'd0, 32'h0000_0001, 32'h0);
    chk("badctl_c1_done", 32'(done), 32'h1);
    chk("badctl_c1_err", 32'(err), 32'h1);
    chk("badctl_c1_data_out", data_out, 32'h0);
    step();
    chk("badctl_c2_busy", 32'(busy), 32'h0);
    idle(2);

    // ---- full channel (ctrl 10): noise XOR when enabled, rejected otherwise ----
    stub_cw = 32'h0000_00A5;
    issue(2'b10, 32'd0, 32'h0000_0003, 32'hFFFF_FF0F);
`ifdef ECC_ENC_NOISE_EN
    chk("full_c1_err", 32'(err), 32'h0);
    idle(2);
    chk("full_c3_done", 32'(done), 32'h1);
    chk("full_c3_data_out", data_out, 32'h0000_00AA);
`else
    chk("full_off_c1_done", 32'(done), 32'h1);
    chk("full_off_c1_err", 32'(err), 32'h1);
    chk("full_off_c1_data_out", data_out, 32'h0);
`endif
    idle(6);

    // ---- start while busy: pulses in cycles 1 and 2 are ignored ----
    stub_cw = 32'h0000_5A5A;
    issue(2'b00, 32'd1, 32'h0000_0000, 32'h0);
    done_cnt  = 0;
    done_cnt3 = 0;
    for (int i = 1; i <= 8; i++) begin
      if (done === 1'b1) done_cnt++;
      if (done3 === 1'b1) done_cnt3++;
      if (i <= 2) begin
        ctrl     = 2'b00;
        work_mod = 32'd2;
        data_in  = 32'hFFFF_FFFF;
        start    = 1'b1;
      end else begin
        start    = 1'b0;
      end
      step();
    end
    chk("busy_start_done_count", 32'(done_cnt), 32'd1);
    chk("busy_start_done_count_lat3", 32'(done_cnt3), 32'd1);
    chk("busy_start_enc_work_mod", enc_work_mod, 32'd1);
    chk("busy_start_enc_data_in", 32'(enc_data_in), 32'h0);
    chk("busy_start_data_out", data_out, 32'h0000_5A5A);
    chk("busy_start_idle", 32'(busy), 32'h0);

    // ---- reset in the middle of WAIT ----
    stub_cw = 32'h1234_5678;
    issue(2'b00, 32'd2, 32'h0ABC_DEF0, 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_enc_data_in", 32'(enc_data_in), 32'h0);
    chk("midrst_enc_work_mod", enc_work_mod, 32'h0);
    chk("midrst_data_out", data_out, 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_busy_lat3", 32'(busy3), 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done === 1'b1 || done3 === 1'b1) done_cnt++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done === 1'b1 || done3 === 1'b1) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    issue(2'b00, 32'd2, 32'hFFFF_FFFF, 32'h0);
    chk("postrst_c1_enc_data_in", 32'(enc_data_in), 32'h03FF_FFFF);
    idle(2);
    chk("postrst_c3_done", 32'(done), 32'h1);
    chk("postrst_c3_data_out", data_out, 32'h1234_5678);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ecc_enc_ctrl.md
# ecc_enc_ctrl

Sequencing controller for the ECC encoder stage. It accepts a single-cycle operation request from the register front end, latches and sanitises the operands, and drives the encoder stage inputs. After the stage's fixed latency it captures the codeword, optionally XORs in channel noise, and reports completion with `operation_done`. It sits between the APB register file and the encoder stage (`ENC_STAGE_1` family) and owns all of that stage's input timing.

## Interface
- `AMBA_WORD`, 32, bus word width
- `MAX_CODEWORD_WIDTH`, 32, widest codeword
- `MAX_INFO_WIDTH`, 26, widest info field
- `ENC_LATENCY`, 1, encoder stage register latency in cycles; legal range ≥1
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-low
- `start`  in  1  operation request pulse
- `ctrl`  in  2  operation: 00 encode, 10 full channel, 01/11 invalid
- `work_mod`  in  AMBA_WORD  codeword mode: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, other values invalid
- `data_in`  in  AMBA_WORD  info word
- `noise`  in  AMBA_WORD  noise vector
- `enc_data_in`  out  MAX_INFO_WIDTH  to encoder stage
- `enc_work_mod`  out  AMBA_WORD  to encoder stage
- `enc_data_out`  in  MAX_CODEWORD_WIDTH  codeword from encoder stage
- `data_out`  out  AMBA_WORD  result word
- `operation_done`  out  1  one-cycle completion pulse
- `mode_err`  out  1  qualifies `operation_done` as a rejected request
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, LOAD, WAIT, DONE, ERR.
- **IDLE, `start`=1:**
  - Latch `ctrl`, `work_mod` and `noise`.
  - If `ctrl` or `work_mod` is invalid, go to ERR.
  - Otherwise go to LOAD.
  - In both cases, register `enc_work_mod` = `work_mod` and `enc_data_in` = `data_in` masked to the info width: 4, 11 or 26 bits; upper bits forced to 0.
- **LOAD:** 1 cycle. Set the latency counter to `ENC_LATENCY`-1, then go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture `data_out` = `enc_data_out` masked to the codeword width (8, 16 or 32 bits) and zero-extended.
  - For full-channel operation, additionally XOR the captured value with `noise` under the same mask.
  - Then go to DONE.
- **DONE:** `operation_done`=1 for 1 cycle, then go to IDLE.
- **ERR:** `operation_done`=1, `mode_err`=1 and `data_out`=0 for 1 cycle, then go to IDLE.
- `start` is ignored outside IDLE; there is no queueing.
- `enc_data_in` and `enc_work_mod` hold their values from LOAD until the next accepted `start`.
- `data_out` holds its value until the next capture or ERR.
- **Reset:**
  - All outputs are 0: `enc_data_in`, `enc_work_mod`, `data_out`, `operation_done`, `mode_err`, `busy`.
  - The state returns to IDLE and the counter is 0.
  - Reset asserted mid-operation aborts the operation; no `operation_done` is generated.

## Timing
- `start` is sampled at edge 0.
- LOAD occupies cycle 1; the encoder inputs are valid from cycle 1.
- WAIT occupies cycles 2 … 1+`ENC_LATENCY`.
- `operation_done` is high in cycle 2+`ENC_LATENCY`; this is cycle 3 at the default latency.
- An invalid request has `operation_done` and `mode_err` high in cycle 1.
- `busy` is high from cycle 1 through the done/error cycle.
- The earliest next accepted `start` is in the first cycle after `operation_done`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `ECC_ENC_NOISE_EN`.
- **Defined:** `ctrl`=10 performs full-channel operation; the noise is XORed into the captured codeword as above.
- **Undefined:**
  - `ctrl`=10 is treated as invalid and goes to ERR.
  - The `noise` port remains present but is unused, with no noise register.

## Structure
- Shared package `ecc_pkg` holds:
  - the state enum;
  - the ctrl encodings (`CTRL_ENC`, `CTRL_FULL`);
  - the mode constants (`MOD_1`..`MOD_3`);
  - the info widths (4/11/26) and codeword widths (8/16/32).
- One sub-module, `ecc_width_mask`: combinational, maps the mode to the info mask and the codeword mask.
- The counter is `$clog2(ENC_LATENCY+1)` bits wide.

## Test plan
- **Mode-2 encode masking:** `work_mod`=1, `ctrl`=00, `data_in`=32'hFFFF_FFFF → `enc_data_in`=26'h00007FF in cycle 1; `operation_done` in cycle 3; `data_out` equals the golden-model codeword with bits [31:16]=0.
- **Full channel with noise:**
  - Setup: `ECC_ENC_NOISE_EN` defined; stub encoder returns 32'h0000_00A5.
  - Stimulus: `work_mod`=0, `ctrl`=10, `noise`=32'hFFFF_FF0F.
  - Required: `data_out`=32'h0000_00AA.
- **Invalid `work_mod`:** `work_mod`=3 → in cycle 1, `operation_done`=1, `mode_err`=1, `data_out`=0; then IDLE. Repeat with `ctrl`=01 and expect the same response.
- **Start while busy:** second `start` pulses in cycles 1 and 2 are ignored → exactly one `operation_done`; the second operand is never latched.
- **Reset mid-operation:** `rst` low during WAIT → all outputs 0 immediately; no `operation_done`; a new `start` after release completes normally.
- **Latency sweep:** `ENC_LATENCY`=3 → `operation_done` in cycle 5; `busy` high in cycles 1–5.
